// File: rtl/midi_msg_rx.sv
// midi_msg_rx: MIDI input block. A UART byte receiver runs on the
// synchronised line and feeds a message parser that reports complete
// channel-voice messages, passes realtime bytes through, and flags
// framing errors.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   midi_in      raw MIDI serial line (idles high)
//   msg_valid    one-cycle strobe, complete message on msg_*
//   msg_status   status byte of last reported message
//   msg_data1    first data byte
//   msg_data2    second data byte (0 for one-data-byte messages)
//   rt_valid     one-cycle strobe, realtime byte received
//   rt_byte      last realtime byte
//   framing_err  one-cycle strobe, stop bit sampled low
//   busy         receiver is inside a byte frame
module midi_msg_rx #(
    parameter int unsigned CLKS_PER_BIT = 128,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter logic [15:0] CHANNEL_MASK = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       midi_in,
    output logic       msg_valid,
    output logic [7:0] msg_status,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2,
    output logic       rt_valid,
    output logic [7:0] rt_byte,
    output logic       framing_err,
    output logic       busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
    typedef enum logic [1:0] {P_WAIT_STATUS, P_WAIT_D1, P_WAIT_D2} p_state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   line_s;
    logic                   line_prev_r;

    rx_state_t   rx_state_r, rx_next_s;
    logic [CW-1:0] cnt_r, cnt_next_s;
    logic [2:0]  bit_idx_r, bit_next_s;
    logic [7:0]  shift_r, shift_next_s;
    logic        byte_stb_s, frame_err_s;

    p_state_t    p_state_r, p_next_s;
    logic [7:0]  rs_r, rs_next_s;
    logic        rs_valid_r, rs_valid_next_s;
    logic [6:0]  d1_r, d1_next_s;
    logic        done_s, rt_load_s, report_s, one_byte_s;
    logic [6:0]  done_d1_s, done_d2_s;

    logic        msg_valid_r, rt_valid_r, framing_err_r, busy_r;
    logic [7:0]  msg_status_r, rt_byte_r;
    logic [6:0]  msg_data1_r, msg_data2_r;

    assign line_s     = sync_r[SYNC_STAGES-1];
    // Program change and channel pressure carry a single data byte.
    assign one_byte_s = (rs_r[7:4] == 4'hC) || (rs_r[7:4] == 4'hD);
    assign report_s   = done_s && CHANNEL_MASK[rs_r[3:0]];

    // Input synchroniser and previous-line register; resets to idle-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r      <= '1;
            line_prev_r <= 1'b1;
        end else begin
            sync_r      <= {sync_r[SYNC_STAGES-2:0], midi_in};
            line_prev_r <= line_s;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_r <= RX_IDLE;
            cnt_r      <= '0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
        end else begin
            rx_state_r <= rx_next_s;
            cnt_r      <= cnt_next_s;
            bit_idx_r  <= bit_next_s;
            shift_r    <= shift_next_s;
        end
    end

    // Receiver next-state: cnt counts cycles since the falling edge (start)
    // or since the previous sample point (data/stop bits).
    always_comb begin
        rx_next_s    = rx_state_r;
        cnt_next_s   = cnt_r;
        bit_next_s   = bit_idx_r;
        shift_next_s = shift_r;
        byte_stb_s   = 1'b0;
        frame_err_s  = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                if (line_prev_r && !line_s) begin
                    rx_next_s  = RX_START;
                    cnt_next_s = ONE;
                end else begin
                    rx_next_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_r == HALF) begin
                    if (line_s) begin
                        rx_next_s = RX_IDLE;
                    end else begin
                        rx_next_s  = RX_DATA;
                        cnt_next_s = ONE;
                        bit_next_s = 3'd0;
                    end
                end else begin
                    cnt_next_s = cnt_r + ONE;
                end
            end
            RX_DATA: begin
                if (cnt_r == FULL) begin
                    shift_next_s = {line_s, shift_r[7:1]};
                    cnt_next_s   = ONE;
                    if (bit_idx_r == 3'd7) begin
                        rx_next_s = RX_STOP;
                    end else begin
                        bit_next_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_next_s = cnt_r + ONE;
                end
            end
            RX_STOP: begin
                if (cnt_r == FULL) begin
                    if (line_s) begin
                        byte_stb_s = 1'b1;
                        rx_next_s  = RX_IDLE;
                    end else begin
                        frame_err_s = 1'b1;
                        rx_next_s   = RX_WAIT_HIGH;
                    end
                end else begin
                    cnt_next_s = cnt_r + ONE;
                end
            end
            RX_WAIT_HIGH: begin
                if (line_s) begin
                    rx_next_s = RX_IDLE;
                end else begin
                    rx_next_s = RX_WAIT_HIGH;
                end
            end
            default: rx_next_s = RX_IDLE;
        endcase
    end

    // Parser state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state_r  <= P_WAIT_STATUS;
            rs_r       <= 8'd0;
            rs_valid_r <= 1'b0;
            d1_r       <= 7'd0;
        end else begin
            p_state_r  <= p_next_s;
            rs_r       <= rs_next_s;
            rs_valid_r <= rs_valid_next_s;
            d1_r       <= d1_next_s;
        end
    end

    // Parser next-state; shift_r holds the complete byte when byte_stb_s fires.
    always_comb begin
        p_next_s        = p_state_r;
        rs_next_s       = rs_r;
        rs_valid_next_s = rs_valid_r;
        d1_next_s       = d1_r;
        done_s          = 1'b0;
        done_d1_s       = d1_r;
        done_d2_s       = 7'd0;
        rt_load_s       = 1'b0;
        if (frame_err_s) begin
            p_next_s        = P_WAIT_STATUS;
            rs_valid_next_s = 1'b0;
        end else if (byte_stb_s) begin
            if (shift_r[7:3] == 5'b11111) begin
                rt_load_s = 1'b1;
            end else if (shift_r[7:4] == 4'hF) begin
                rs_valid_next_s = 1'b0;
                p_next_s        = P_WAIT_STATUS;
            end else if (shift_r[7]) begin
                rs_next_s       = shift_r;
                rs_valid_next_s = 1'b1;
                p_next_s        = P_WAIT_D1;
            end else begin
                case (p_state_r)
                    P_WAIT_STATUS, P_WAIT_D1: begin
                        // In WAIT_STATUS a data byte restarts a message only
                        // under a valid running status.
                        if ((p_state_r == P_WAIT_D1) || rs_valid_r) begin
                            d1_next_s = shift_r[6:0];
                            if (one_byte_s) begin
                                done_s    = 1'b1;
                                done_d1_s = shift_r[6:0];
                                p_next_s  = P_WAIT_STATUS;
                            end else begin
                                p_next_s = P_WAIT_D2;
                            end
                        end else begin
                            p_next_s = P_WAIT_STATUS;
                        end
                    end
                    P_WAIT_D2: begin
                        done_s    = 1'b1;
                        done_d1_s = d1_r;
                        done_d2_s = shift_r[6:0];
                        p_next_s  = P_WAIT_STATUS;
                    end
                    default: p_next_s = P_WAIT_STATUS;
                endcase
            end
        end else begin
            p_next_s = p_state_r;
        end
    end

    // Registered outputs: strobes, held message/realtime fields, busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_valid_r   <= 1'b0;
            msg_status_r  <= 8'd0;
            msg_data1_r   <= 7'd0;
            msg_data2_r   <= 7'd0;
            rt_valid_r    <= 1'b0;
            rt_byte_r     <= 8'd0;
            framing_err_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            msg_valid_r   <= report_s;
            rt_valid_r    <= rt_load_s;
            framing_err_r <= frame_err_s;
            busy_r        <= (rx_next_s == RX_START) || (rx_next_s == RX_DATA) ||
                             (rx_next_s == RX_STOP);
            if (report_s) begin
                msg_status_r <= rs_r;
                msg_data1_r  <= done_d1_s;
                msg_data2_r  <= done_d2_s;
            end
            if (rt_load_s) begin
                rt_byte_r <= shift_r;
            end
        end
    end

    assign msg_valid   = msg_valid_r;
    assign msg_status  = msg_status_r;
    assign msg_data1   = msg_data1_r;
    assign msg_data2   = msg_data2_r;
    assign rt_valid    = rt_valid_r;
    assign rt_byte     = rt_byte_r;
    assign framing_err = framing_err_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_midi_msg_rx.sv
// Bench for midi_msg_rx: two instances (all channels / channel 0 only) share
// one serial line; a byte-level reference model predicts every strobe.
module tb_midi_msg_rx;

    localparam int CPB = 16;
    // Sync depth + start-bit centre + nine more bit periods + one register stage.
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;
    localparam logic [15:0] MASK_A = 16'hFFFF;
    localparam logic [15:0] MASK_B = 16'h0001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic midi_in = 1'b1;

    logic a_msg_valid, a_rt_valid, a_framing_err, a_busy;
    logic [7:0] a_msg_status, a_rt_byte;
    logic [6:0] a_msg_data1, a_msg_data2;
    logic b_msg_valid, b_rt_valid, b_framing_err, b_busy;
    logic [7:0] b_msg_status, b_rt_byte;
    logic [6:0] b_msg_data1, b_msg_data2;

    midi_msg_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2), .CHANNEL_MASK(MASK_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .midi_in(midi_in),
        .msg_valid(a_msg_valid), .msg_status(a_msg_status), .msg_data1(a_msg_data1),
        .msg_data2(a_msg_data2), .rt_valid(a_rt_valid), .rt_byte(a_rt_byte),
        .framing_err(a_framing_err), .busy(a_busy));

    midi_msg_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2), .CHANNEL_MASK(MASK_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .midi_in(midi_in),
        .msg_valid(b_msg_valid), .msg_status(b_msg_status), .msg_data1(b_msg_data1),
        .msg_data2(b_msg_data2), .rt_valid(b_rt_valid), .rt_byte(b_rt_byte),
        .framing_err(b_framing_err), .busy(b_busy));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed strobes with the cycle they were seen in.
    logic [21:0] a_mq[$], b_mq[$];
    int a_mc[$], b_mc[$];
    logic [7:0] a_rq[$], b_rq[$];
    int a_rc[$], b_rc[$];
    int a_fc[$], b_fc[$];

    always @(negedge clk) begin
        if (a_msg_valid) begin a_mq.push_back({a_msg_status, a_msg_data1, a_msg_data2}); a_mc.push_back(cyc); end
        if (b_msg_valid) begin b_mq.push_back({b_msg_status, b_msg_data1, b_msg_data2}); b_mc.push_back(cyc); end
        if (a_rt_valid) begin a_rq.push_back(a_rt_byte); a_rc.push_back(cyc); end
        if (b_rt_valid) begin b_rq.push_back(b_rt_byte); b_rc.push_back(cyc); end
        if (a_framing_err) a_fc.push_back(cyc);
        if (b_framing_err) b_fc.push_back(cyc);
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: running status (-1 = none) and collected data bytes.
    int m_rs = -1;
    logic [6:0] m_dq[$];
    logic [21:0] last_a = 22'd0, last_b = 22'd0;
    logic [7:0] last_rt = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_evt(input string tag, input bit en, input logic [31:0] ev, input int ec,
                           input int on, input logic [31:0] ov, input int oc);
        chk({tag, "_count"}, 32'(on), 32'(en));
        if (en && on > 0) begin
            chk({tag, "_value"}, ov, ev);
            chk({tag, "_cycle"}, 32'(oc), 32'(ec));
        end
    endtask

    task automatic model_byte(input logic [7:0] b, output bit is_msg, output logic [21:0] msg,
                              output bit is_rt);
        int need;
        logic [7:0] st;
        logic [6:0] d2;
        is_msg = 1'b0; is_rt = 1'b0; msg = 22'd0;
        if (b >= 8'hF8) is_rt = 1'b1;
        else if (b >= 8'hF0) begin m_rs = -1; m_dq.delete(); end
        else if (b >= 8'h80) begin m_rs = int'(b); m_dq.delete(); end
        else if (m_rs >= 0) begin
            st = m_rs[7:0];
            m_dq.push_back(b[6:0]);
            need = (st[7:4] == 4'hC || st[7:4] == 4'hD) ? 1 : 2;
            if (m_dq.size() == need) begin
                d2 = (need == 2) ? m_dq[1] : 7'd0;
                msg = {st, m_dq[0], d2};
                is_msg = 1'b1;
                m_dq.delete();
            end
        end
    endtask

    task automatic verify(input int ec, input bit ea, input bit eb, input logic [21:0] em,
                          input bit er, input logic [7:0] erv, input bit ef);
        chk_evt("a_msg", ea, 32'(em), ec, a_mq.size(), a_mq.size() > 0 ? 32'(a_mq[0]) : 32'd0,
                a_mc.size() > 0 ? a_mc[0] : -1);
        chk_evt("b_msg", eb, 32'(em), ec, b_mq.size(), b_mq.size() > 0 ? 32'(b_mq[0]) : 32'd0,
                b_mc.size() > 0 ? b_mc[0] : -1);
        chk_evt("a_rt", er, 32'(erv), ec, a_rq.size(), a_rq.size() > 0 ? 32'(a_rq[0]) : 32'd0,
                a_rc.size() > 0 ? a_rc[0] : -1);
        chk_evt("b_rt", er, 32'(erv), ec, b_rq.size(), b_rq.size() > 0 ? 32'(b_rq[0]) : 32'd0,
                b_rc.size() > 0 ? b_rc[0] : -1);
        chk_evt("a_ferr", ef, 32'd0, ec, a_fc.size(), 32'd0, a_fc.size() > 0 ? a_fc[0] : -1);
        chk_evt("b_ferr", ef, 32'd0, ec, b_fc.size(), 32'd0, b_fc.size() > 0 ? b_fc[0] : -1);
        chk("a_msg_hold", 32'({a_msg_status, a_msg_data1, a_msg_data2}), 32'(last_a));
        chk("b_msg_hold", 32'({b_msg_status, b_msg_data1, b_msg_data2}), 32'(last_b));
        chk("a_rt_hold", 32'(a_rt_byte), 32'(last_rt));
        chk("idle_busy", 32'({a_busy, b_busy}), 32'd0);
        a_mq.delete(); a_mc.delete(); b_mq.delete(); b_mc.delete();
        a_rq.delete(); a_rc.delete(); b_rq.delete(); b_rc.delete();
        a_fc.delete(); b_fc.delete();
    endtask

    task automatic send(input logic [7:0] b, input bit ok);
        logic [9:0] bits;
        int p;
        bit is_msg, is_rt, ea, eb;
        logic [21:0] msg;
        bits = {ok, b, 1'b0};
        @(posedge clk); #1;
        p = cyc;
        for (int i = 0; i < 10; i++) begin
            midi_in = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
            if (i == 4) chk("busy_mid", 32'({a_busy, b_busy}), 32'd3);
        end
        midi_in = 1'b1;
        repeat ($urandom_range(2, 6)) @(posedge clk);
        #1;
        is_msg = 1'b0; is_rt = 1'b0; msg = 22'd0;
        if (ok) model_byte(b, is_msg, msg, is_rt);
        else begin m_rs = -1; m_dq.delete(); end
        ea = is_msg && MASK_A[msg[17:14]];
        eb = is_msg && MASK_B[msg[17:14]];
        if (ea) last_a = msg;
        if (eb) last_b = msg;
        if (is_rt) last_rt = b;
        verify(p + LAT, ea, eb, msg, is_rt, b, !ok);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_a_msg"}, 32'({a_msg_valid, a_msg_status, a_msg_data1, a_msg_data2}), 32'd0);
        chk({tag, "_b_msg"}, 32'({b_msg_valid, b_msg_status, b_msg_data1, b_msg_data2}), 32'd0);
        chk({tag, "_a_misc"}, 32'({a_rt_valid, a_rt_byte, a_framing_err, a_busy}), 32'd0);
        chk({tag, "_b_misc"}, 32'({b_rt_valid, b_rt_byte, b_framing_err, b_busy}), 32'd0);
    endtask

    initial begin
        int r;
        logic [7:0] rb;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Note on, then running-status note.
        send(8'h90, 1'b1); send(8'h3C, 1'b1); send(8'h64, 1'b1);
        send(8'h40, 1'b1); send(8'h00, 1'b1);
        // Program change, SysEx clears running status, stray data discarded.
        send(8'hC5, 1'b1); send(8'h07, 1'b1);
        send(8'hF0, 1'b1); send(8'h12, 1'b1); send(8'h33, 1'b1);
        // Realtime interleaved in a message.
        send(8'h90, 1'b1); send(8'h3C, 1'b1); send(8'hF8, 1'b1); send(8'h64, 1'b1);
        // Framing error clears running status.
        send(8'h90, 1'b1); send(8'h3C, 1'b1); send(8'h55, 1'b0); send(8'h22, 1'b1);

        // Short low glitch: no strobe.
        @(posedge clk); #1;
        midi_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        midi_in = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        verify(0, 1'b0, 1'b0, 22'd0, 1'b0, 8'd0, 1'b0);

        // Channel 1 filtered on instance b; channel 0 reported on both.
        send(8'h91, 1'b1); send(8'h3C, 1'b1); send(8'h64, 1'b1);
        send(8'h80, 1'b1); send(8'h3C, 1'b1); send(8'h00, 1'b1);

        // Reset in the middle of a frame.
        send(8'h92, 1'b1);
        @(posedge clk); #1;
        midi_in = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check_reset_outputs("midreset");
        midi_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_rs = -1; m_dq.delete();
        last_a = 22'd0; last_b = 22'd0; last_rt = 8'd0;
        repeat (4) @(posedge clk);
        #1;
        verify(0, 1'b0, 1'b0, 22'd0, 1'b0, 8'd0, 1'b0);
        send(8'h3C, 1'b1);
        send(8'h90, 1'b1); send(8'h3C, 1'b1); send(8'h64, 1'b1);

        // Randomised byte stream.
        for (int k = 0; k < 90; k++) begin
            r = int'($urandom_range(0, 19));
            if (r < 10) rb = 8'($urandom_range(0, 127));
            else if (r < 14) rb = 8'($urandom_range(8'h80, 8'hEF));
            else if (r < 16) rb = 8'($urandom_range(8'hF8, 8'hFF));
            else if (r < 18) rb = 8'($urandom_range(8'hF0, 8'hF7));
            else rb = 8'($urandom_range(0, 255));
            send(rb, r != 19);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
